// File: rtl/blocpu_pkg.sv
// ---------------------------------------------------------------------------
// blocpu_pkg
// Shared definitions for the blocpu program loader: core geometry, the
// framing bytes used on the UART link and the loader state enumeration.
// No ports (package).
// ---------------------------------------------------------------------------
package blocpu_pkg;

  localparam int         BLOCPU_INSTR_W   = 12;
  localparam int         BLOCPU_ADDR_W    = 16;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LOADER_ACK_BYTE  = 8'h06;
  localparam logic [7:0] LOADER_NAK_BYTE  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loaderState_e;

endpackage

// File: rtl/blocpu_loader_timeout.sv
// ---------------------------------------------------------------------------
// blocpu_loader_timeout
// Inter-byte watchdog for the program loader. Counts enabled cycles since the
// last clear and flags expiry once the count reaches TIMEOUT_CYCLES-1. The
// counter saturates there so expiry stays visible until the loader reacts.
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   clear_i    restart the count (received byte, or loader not busy)
//   enable_i   count while a frame is in progress
//   expired_o  count has reached TIMEOUT_CYCLES-1 while enabled
// ---------------------------------------------------------------------------
module blocpu_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int               CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Clear has priority so a byte arriving on the expiry cycle still counts
  // as activity; otherwise count up and hold at the terminal value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/blocpu_program_loader.sv
// ---------------------------------------------------------------------------
// blocpu_program_loader
// Boot sequencer for blocpu_core. Parses a framed program from the UART byte
// stream (SYNC, N, N x {hi,lo}, CHK), writes each 12-bit instruction through
// the core's write port while holding the core in reset, checks the XOR
// checksum and then releases reset and starts the core.
// Optional feature: define LOADER_ECHO_EN to add tx_start_o/tx_data_o, which
// pulse an ACK (06) on frame acceptance or a NAK (15) on any error.
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i  received byte strobe and data
//   core_running_i    core status (informational only)
//   core_reset_o      core held in reset when 1
//   core_run_o        core run enable
//   instr_o, instr_addr_o, instr_write_o  instruction write port
//   busy_o            frame in progress
//   loaded_o          last frame accepted and core released
//   error_o           sticky error until the next SYNC byte
//   tx_start_o, tx_data_o  (LOADER_ECHO_EN) ACK/NAK send strobe and byte
// ---------------------------------------------------------------------------
module blocpu_program_loader
  import blocpu_pkg::*;
#(
  parameter int         ADDR_W         = BLOCPU_ADDR_W,
  parameter int         INSTR_W        = BLOCPU_INSTR_W,
  parameter logic [7:0] SYNC_BYTE      = LOADER_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  input  logic               core_running_i,
  output logic               core_reset_o,
  output logic               core_run_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_addr_o,
  output logic               instr_write_o,
  output logic               busy_o,
  output logic               loaded_o,
  output logic               error_o
`ifdef LOADER_ECHO_EN
  ,
  output logic               tx_start_o,
  output logic [7:0]         tx_data_o
`endif
);

  loaderState_e       state_q, state_d;
  logic               coreReset_q, coreRun_q, instrWrite_q;
  logic               busy_q, loaded_q, error_q, overrun_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instrAddr_q, addr_q;
  logic [7:0]         chkAcc_q;
  logic [3:0]         hiNib_q;
  logic [8:0]         remaining_q;
  logic               syncHit, timerEn, timedOut, enterDone;
  logic               unusedCoreRunning;

  assign unusedCoreRunning = core_running_i;

  assign syncHit   = rx_valid_i && (rx_data_i == SYNC_BYTE);
  assign timerEn   = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign enterDone = (state_q == ST_CHECK) && (state_d == ST_DONE);

  blocpu_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (rx_valid_i || !timerEn),
    .enable_i (timerEn),
    .expired_o(timedOut)
  );

  // Next-state decode. A received byte always wins over a simultaneous
  // timeout. The write sequence never waits, and overrun/timeout are only
  // acted on once WR_HOLD completes so a started write is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (syncHit) state_d = ST_COUNT;
      ST_COUNT: begin
        if (rx_valid_i)    state_d = ST_HI;
        else if (timedOut) state_d = ST_ERR;
      end
      ST_HI: begin
        if (rx_valid_i)    state_d = (rx_data_i[7:4] != 4'h0) ? ST_ERR : ST_LO;
        else if (timedOut) state_d = ST_ERR;
      end
      ST_LO: begin
        if (rx_valid_i)    state_d = ST_WR_SETUP;
        else if (timedOut) state_d = ST_ERR;
      end
      ST_WR_SETUP:  state_d = ST_WR_STROBE;
      ST_WR_STROBE: state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (overrun_q || rx_valid_i || timedOut) state_d = ST_ERR;
        else if (remaining_q == 9'd1)            state_d = ST_CHECK;
        else                                     state_d = ST_HI;
      end
      ST_CHECK: begin
        if (rx_valid_i)    state_d = (rx_data_i == chkAcc_q) ? ST_DONE : ST_ERR;
        else if (timedOut) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and all registered outputs. Outputs are derived from the
  // transition being taken so they change on the same edge as the state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      coreReset_q  <= 1'b1;
      coreRun_q    <= 1'b0;
      instr_q      <= '0;
      instrAddr_q  <= '0;
      instrWrite_q <= 1'b0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      error_q      <= 1'b0;
      overrun_q    <= 1'b0;
      addr_q       <= '0;
      chkAcc_q     <= '0;
      hiNib_q      <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      instrWrite_q <= (state_d == ST_WR_STROBE);

      if (syncHit && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
        coreReset_q <= 1'b1;
        coreRun_q   <= 1'b0;
        loaded_q    <= 1'b0;
        error_q     <= 1'b0;
        busy_q      <= 1'b1;
        overrun_q   <= 1'b0;
        addr_q      <= '0;
        chkAcc_q    <= '0;
      end

      if (rx_valid_i && ((state_q == ST_COUNT) || (state_q == ST_HI) || (state_q == ST_LO)))
        chkAcc_q <= chkAcc_q ^ rx_data_i;

      // A count byte of zero encodes a full 256-instruction frame.
      if (rx_valid_i && (state_q == ST_COUNT))
        remaining_q <= (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};

      if (rx_valid_i && (state_q == ST_HI))
        hiNib_q <= rx_data_i[3:0];

      if (rx_valid_i && (state_q == ST_LO)) begin
        instr_q     <= INSTR_W'({hiNib_q, rx_data_i});
        instrAddr_q <= addr_q;
      end

      // Bytes landing mid-write are dropped but remembered as an overrun.
      if (rx_valid_i && ((state_q == ST_WR_SETUP) || (state_q == ST_WR_STROBE)))
        overrun_q <= 1'b1;

      if (state_q == ST_WR_HOLD) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - 9'd1;
      end

      if (state_d == ST_ERR) begin
        error_q     <= 1'b1;
        busy_q      <= 1'b0;
        coreReset_q <= 1'b1;
        coreRun_q   <= 1'b0;
      end

      if (enterDone) begin
        coreReset_q <= 1'b0;
        loaded_q    <= 1'b1;
        busy_q      <= 1'b0;
      end

      // Run follows reset release by one cycle.
      if ((state_q == ST_DONE) && (state_d == ST_DONE))
        coreRun_q <= 1'b1;
    end
  end

`ifdef LOADER_ECHO_EN
  logic       txStart_q;
  logic [7:0] txData_q;

  // One-cycle ACK/NAK strobe on entry to DONE or ERR.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      txStart_q <= 1'b0;
      txData_q  <= '0;
    end else begin
      txStart_q <= enterDone || (state_d == ST_ERR);
      if (state_d == ST_ERR) txData_q <= LOADER_NAK_BYTE;
      else if (enterDone)    txData_q <= LOADER_ACK_BYTE;
    end
  end

  assign tx_start_o = txStart_q;
  assign tx_data_o  = txData_q;
`endif

  assign core_reset_o  = coreReset_q;
  assign core_run_o    = coreRun_q;
  assign instr_o       = instr_q;
  assign instr_addr_o  = instrAddr_q;
  assign instr_write_o = instrWrite_q;
  assign busy_o        = busy_q;
  assign loaded_o      = loaded_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_blocpu_program_loader.sv
// ---------------------------------------------------------------------------
// tb_blocpu_program_loader
// Scoreboard bench for the program loader. The stimulus side builds frames,
// pushes the instruction writes and frame outcome it expects, and a separate
// monitor pops and compares whenever the loader strobes a write or reports a
// result. Define LOADER_ECHO_EN to also check the ACK/NAK echo.
// ---------------------------------------------------------------------------
module tb_blocpu_program_loader;

  localparam int         TIMEOUT = 64;
  localparam logic [7:0] SYNC    = 8'hA5;

  localparam int K_OK      = 0;
  localparam int K_BADCHK  = 1;
  localparam int K_FORMAT  = 2;
  localparam int K_OVERRUN = 3;
  localparam int K_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        coreRunning;
  logic        core_reset_o, core_run_o, instr_write_o, busy_o, loaded_o, error_o;
  logic [11:0] instr_o;
  logic [15:0] instr_addr_o;
`ifdef LOADER_ECHO_EN
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
`endif

  int checks = 0;
  int errors = 0;

  // Expected writes as {addr, instr}; expected outcomes as 1 = accepted.
  logic [27:0] expWrites[$];
  logic        expResults[$];

  always #5 clk = ~clk;

  blocpu_program_loader #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .core_running_i(coreRunning),
    .core_reset_o  (core_reset_o),
    .core_run_o    (core_run_o),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .instr_write_o (instr_write_o),
    .busy_o        (busy_o),
    .loaded_o      (loaded_o),
    .error_o       (error_o)
`ifdef LOADER_ECHO_EN
    ,
    .tx_start_o    (tx_start_o),
    .tx_data_o     (tx_data_o)
`endif
  );

  // Single comparison point for both processes.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".coreReset"}, core_reset_o, 1);
    checkOutput({tag, ".coreRun"}, core_run_o, 0);
    checkOutput({tag, ".instr"}, instr_o, 0);
    checkOutput({tag, ".instrAddr"}, instr_addr_o, 0);
    checkOutput({tag, ".instrWrite"}, instr_write_o, 0);
    checkOutput({tag, ".busy"}, busy_o, 0);
    checkOutput({tag, ".loaded"}, loaded_o, 0);
    checkOutput({tag, ".error"}, error_o, 0);
  endtask

  // Called at a negedge: presents one byte for one cycle, then idles.
  task automatic applyStimulus(input logic [7:0] b, input int idleAfter);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (idleAfter) @(negedge clk);
  endtask

  // Waits, bounded, for the monitor to consume the pending outcome.
  task automatic waitResult();
    int cyc = 0;
    while ((expResults.size() != 0) && (cyc < TIMEOUT + 100)) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("resultSeen", expResults.size(), 0);
    repeat (4) @(negedge clk);
    checkOutput("writesDrained", expWrites.size(), 0);
  endtask

  // Builds and sends one frame. 'where' selects the pair at which a format
  // error, overrun or timeout is injected; the checksum is the XOR of the
  // count byte and every payload byte.
  task automatic runFrame(input logic [11:0] ins[$], input int kind, input int where);
    int         n;
    logic [7:0] nb, chk, hi, lo;
    n   = ins.size();
    nb  = 8'(n);
    chk = nb;
    applyStimulus(SYNC, $urandom_range(0, 3));
    applyStimulus(nb, $urandom_range(0, 4));
    for (int i = 0; i < n; i++) begin
      hi = {4'h0, ins[i][11:8]};
      lo = ins[i][7:0];
      if ((kind == K_FORMAT) && (i == where)) begin
        hi[7:4] = 4'($urandom_range(1, 15));
        expResults.push_back(1'b0);
        applyStimulus(hi, 0);
        waitResult();
        return;
      end
      applyStimulus(hi, $urandom_range(0, 4));
      if ((kind == K_TIMEOUT) && (i == where)) begin
        expResults.push_back(1'b0);
        waitResult();
        return;
      end
      expWrites.push_back({16'(i), ins[i]});
      if ((kind == K_OVERRUN) && (i == where)) begin
        expResults.push_back(1'b0);
        applyStimulus(lo, $urandom_range(0, 2));
        applyStimulus(8'($urandom), 0);
        waitResult();
        return;
      end
      applyStimulus(lo, $urandom_range(3, 6));
      chk = chk ^ hi ^ lo;
    end
    if (kind == K_BADCHK) chk = chk ^ 8'($urandom_range(1, 255));
    expResults.push_back(kind == K_OK);
    applyStimulus(chk, 0);
    waitResult();
  endtask

  // Monitor: compares every write strobe and every reported outcome against
  // the head of the corresponding expectation queue.
  initial begin
    logic        prevWrite = 1'b0, prevLoaded = 1'b0, prevError = 1'b0;
    logic        runPending = 1'b0, holdPending = 1'b0;
    logic [27:0] exp;
    logic        res;
    logic [27:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevWrite = 1'b0; prevLoaded = 1'b0; prevError = 1'b0;
        runPending = 1'b0; holdPending = 1'b0;
      end else begin
        if (holdPending) begin
          checkOutput("holdAddr", instr_addr_o, held[27:12]);
          checkOutput("holdInstr", instr_o, held[11:0]);
          holdPending = 1'b0;
        end
        if (instr_write_o) begin
          checkOutput("writePulse", prevWrite, 0);
          checkOutput("writeQueued", expWrites.size() > 0, 1);
          if (expWrites.size() > 0) begin
            exp = expWrites.pop_front();
            checkOutput("writeAddr", instr_addr_o, exp[27:12]);
            checkOutput("writeInstr", instr_o, exp[11:0]);
            held = exp;
            holdPending = 1'b1;
          end
        end
        if (runPending) begin
          checkOutput("runAfterRelease", core_run_o, 1);
          runPending = 1'b0;
        end
        if ((loaded_o && !prevLoaded) || (error_o && !prevError)) begin
          checkOutput("resultQueued", expResults.size() > 0, 1);
          res = (expResults.size() > 0) ? expResults.pop_front() : 1'b0;
          checkOutput("outcome", loaded_o, res);
          checkOutput("outcomeErr", error_o, !res);
          checkOutput("outcomeBusy", busy_o, 0);
          checkOutput("outcomeCoreReset", core_reset_o, !res);
          checkOutput("outcomeCoreRun", core_run_o, 0);
`ifdef LOADER_ECHO_EN
          checkOutput("echoStart", tx_start_o, 1);
          checkOutput("echoData", tx_data_o, res ? 8'h06 : 8'h15);
`endif
          runPending = loaded_o;
        end
        prevWrite  = instr_write_o;
        prevLoaded = loaded_o;
        prevError  = error_o;
      end
    end
  end

  // Directed frames first, then randomized frames, then async reset and a
  // full 256-instruction frame.
  initial begin
    logic [11:0] ins[$];
    int          kind, n;
    rst_n       = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    coreRunning = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("initReset");
    rst_n = 1'b1;
    @(negedge clk);

    ins = '{12'hE02, 12'hF0D};
    runFrame(ins, K_OK, 0);
    checkOutput("t1Loaded", loaded_o, 1);
    checkOutput("t1CoreRun", core_run_o, 1);
    checkOutput("t1CoreReset", core_reset_o, 0);

    runFrame(ins, K_BADCHK, 0);
    checkOutput("t2Error", error_o, 1);
    checkOutput("t2CoreReset", core_reset_o, 1);
    checkOutput("t2CoreRun", core_run_o, 0);

    ins = '{12'hE02};
    runFrame(ins, K_FORMAT, 0);

    ins = '{12'hE00};
    runFrame(ins, K_TIMEOUT, 0);
    checkOutput("t4Error", error_o, 1);
    checkOutput("t4Busy", busy_o, 0);
    applyStimulus(SYNC, 0);
    checkOutput("t4ErrorCleared", error_o, 0);
    checkOutput("t4BusyAgain", busy_o, 1);
    expResults.push_back(1'b0);
    waitResult();

    ins = '{12'h123, 12'h456};
    runFrame(ins, K_OVERRUN, 0);

    repeat (25) begin
      n    = $urandom_range(1, 8);
      kind = $urandom_range(0, 4);
      ins.delete();
      for (int i = 0; i < n; i++) ins.push_back(12'($urandom));
      runFrame(ins, kind, $urandom_range(0, n - 1));
    end

    applyStimulus(SYNC, 1);
    applyStimulus(8'h04, 1);
    expWrites.push_back({16'h0000, 12'h123});
    applyStimulus(8'h01, 2);
    applyStimulus(8'h23, 5);
    applyStimulus(8'h04, 1);
    checkOutput("t6BusyBefore", busy_o, 1);
    #3 rst_n = 1'b0;
    #1 checkReset("asyncReset");
    expWrites.delete();
    expResults.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    ins.delete();
    for (int i = 0; i < 256; i++) ins.push_back(12'($urandom));
    runFrame(ins, K_OK, 0);
    checkOutput("t6LastAddr", instr_addr_o, 16'h00FF);
    checkOutput("t6Loaded", loaded_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
